// File: rtl/updown_pkg.sv
// Shared encodings for the parametrised up/down counter family.
// Direction and run-mode codes are 2 bits wide to match the top-level ports.
package updown_pkg;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_SAT    = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

endpackage

// File: rtl/updown_step.sv
// Combinational next-state for one enabled step of the counter.
// hit_end flags a destination equal to the endpoint in the pre-edge direction.
module updown_step
    import updown_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 25
) (
    input  logic [WIDTH-1:0] count,
    input  logic [1:0]       dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_count,
    output logic [1:0]       next_dir,
    output logic             hit_end
);

    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ZERO_W = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] w_cnt_ext;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;
    logic           w_at_top;
    logic           w_at_bot;

    assign w_cnt_ext = {1'b0, count};
    assign w_inc     = w_cnt_ext + ONE_W;
    assign w_dec     = w_cnt_ext - ONE_W;
    assign w_at_top  = (w_cnt_ext >= MAX_W);
    assign w_at_bot  = (w_cnt_ext == ZERO_W);

    // Mode/direction decode; an out-of-range step in BOUNCE turns back inward.
    always_comb begin
        next_count = count;
        next_dir   = dir;
        hit_end    = 1'b0;
        case (mode)
            MODE_WRAP: begin
                case (dir)
                    DIR_UP: begin
                        if (w_at_top) begin
                            next_count = {WIDTH{1'b0}};
                        end else begin
                            next_count = w_inc[WIDTH-1:0];
                            hit_end    = (w_inc == MAX_W);
                        end
                    end
                    DIR_DOWN: begin
                        if (w_at_bot) begin
                            next_count = MAX_W[WIDTH-1:0];
                        end else begin
                            next_count = w_dec[WIDTH-1:0];
                            hit_end    = (w_dec == ZERO_W);
                        end
                    end
                    default: next_count = count;
                endcase
            end
            MODE_BOUNCE: begin
                case (dir)
                    DIR_UP: begin
                        if (w_at_top) begin
                            next_count = MAX_W[WIDTH-1:0] - {{(WIDTH-1){1'b0}}, 1'b1};
                            next_dir   = DIR_DOWN;
                        end else begin
                            next_count = w_inc[WIDTH-1:0];
                            hit_end    = (w_inc == MAX_W);
                            next_dir   = (w_inc == MAX_W) ? DIR_DOWN : DIR_UP;
                        end
                    end
                    DIR_DOWN: begin
                        if (w_at_bot) begin
                            next_count = w_inc[WIDTH-1:0];
                            next_dir   = DIR_UP;
                        end else begin
                            next_count = w_dec[WIDTH-1:0];
                            hit_end    = (w_dec == ZERO_W);
                            next_dir   = (w_dec == ZERO_W) ? DIR_UP : DIR_DOWN;
                        end
                    end
                    default: next_count = count;
                endcase
            end
            MODE_SAT: begin
                case (dir)
                    DIR_UP: begin
                        if (w_at_top) begin
                            next_dir = DIR_IDLE;
                        end else begin
                            next_count = w_inc[WIDTH-1:0];
                            hit_end    = (w_inc == MAX_W);
                            next_dir   = (w_inc == MAX_W) ? DIR_IDLE : DIR_UP;
                        end
                    end
                    DIR_DOWN: begin
                        if (w_at_bot) begin
                            next_dir = DIR_IDLE;
                        end else begin
                            next_count = w_dec[WIDTH-1:0];
                            hit_end    = (w_dec == ZERO_W);
                            next_dir   = (w_dec == ZERO_W) ? DIR_IDLE : DIR_DOWN;
                        end
                    end
                    default: next_count = count;
                endcase
            end
            default: next_count = count;
        endcase
    end

endmodule

// File: rtl/updown_counter_param.sv
// Modulo-MODULUS up/down counter with wrap/bounce/saturate modes, clamped
// synchronous load, direction control and a registered terminal-count pulse.
module updown_counter_param
    import updown_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 25
) (
    input  logic             Clk,
    input  logic             ClearN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start_up,
    input  logic             start_down,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       dir,
    output logic             tc
);

    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);

    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
        $error("updown_counter_param: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] r_count;
    logic [1:0]       r_dir;
    logic             r_tc;
    logic [WIDTH-1:0] w_next_count;
    logic [1:0]       w_next_dir;
    logic             w_hit_end;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_ctl;

    assign w_load_clamped = ({1'b0, load_val} > MAX_W) ? MAX_W[WIDTH-1:0] : load_val;
    assign w_ctl          = load | start_up | start_down;

    updown_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .count      (r_count),
        .dir        (r_dir),
        .mode       (mode),
        .next_count (w_next_count),
        .next_dir   (w_next_dir),
        .hit_end    (w_hit_end)
    );

    // Load/start outrank stepping; any control cycle suppresses the step.
    always_ff @(posedge Clk or negedge ClearN) begin
        if (!ClearN) begin
            r_count <= {WIDTH{1'b0}};
            r_dir   <= DIR_IDLE;
            r_tc    <= 1'b0;
        end else if (w_ctl) begin
            r_tc <= 1'b0;
            if (load) begin
                r_count <= w_load_clamped;
            end else begin
                r_count <= r_count;
            end
            if (start_up && !start_down) begin
                r_dir <= DIR_UP;
            end else if (start_down && !start_up) begin
                r_dir <= DIR_DOWN;
            end else begin
                r_dir <= r_dir;
            end
        end else if (en) begin
            r_count <= w_next_count;
            r_dir   <= w_next_dir;
            r_tc    <= w_hit_end;
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count;
    assign dir   = r_dir;
    assign tc    = r_tc;

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench: the driver queues hand-computed {count,dir,tc} per edge,
// a negedge monitor pops and compares. Second instance covers WIDTH=3/MODULUS=8.
module tb_updown_counter_param;
    import updown_pkg::*;

    typedef struct {
        logic [4:0] cnt;
        logic [1:0] dir;
        logic       tc;
        int         tag;
    } exp_t;

    logic       Clk;
    logic       ClearN;
    logic       load;
    logic [4:0] load_val;
    logic [2:0] load_val2;
    logic       start_up;
    logic       start_down;
    logic       en;
    logic [1:0] mode;
    logic [4:0] count;
    logic [1:0] dir;
    logic       tc;
    logic [2:0] count2;
    logic [1:0] dir2;
    logic       tc2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   tag     = 0;

    updown_counter_param #(.WIDTH(5), .MODULUS(25)) dut (
        .Clk(Clk), .ClearN(ClearN), .load(load), .load_val(load_val),
        .start_up(start_up), .start_down(start_down), .en(en), .mode(mode),
        .count(count), .dir(dir), .tc(tc)
    );

    updown_counter_param #(.WIDTH(3), .MODULUS(8)) dut2 (
        .Clk(Clk), .ClearN(ClearN), .load(load), .load_val(load_val2),
        .start_up(start_up), .start_down(start_down), .en(en), .mode(mode),
        .count(count2), .dir(dir2), .tc(tc2)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got still running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string what, input int t, input logic [4:0] ac, input logic [1:0] ad,
                       input logic at, input logic [4:0] ec, input logic [1:0] ed, input logic et);
        n_total++;
        if (ac === ec && ad === ed && at === et) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got count=%0d dir=%b tc=%b, want count=%0d dir=%b tc=%b",
                     what, t, ac, ad, at, ec, ed, et);
        end
    endtask

    // Monitor: outputs are always presented, so compare one entry per cycle.
    always @(negedge Clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("dut_m25", e.tag, count, dir, tc, e.cnt, e.dir, e.tc);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            chk("dut_m8", e.tag, {2'b00, count2}, dir2, tc2, e.cnt, e.dir, e.tc);
        end
    end

    task automatic step(input logic ld, input logic [4:0] lv, input logic su, input logic sd,
                        input logic e, input logic [1:0] md,
                        input logic [4:0] ec, input logic [1:0] ed, input logic et);
        load = ld; load_val = lv; load_val2 = 3'd0;
        start_up = su; start_down = sd; en = e; mode = md;
        @(posedge Clk); #1;
        tag++;
        q1.push_back('{ec, ed, et, tag});
        @(negedge Clk); #1;
    endtask

    task automatic step2(input logic ld, input logic [2:0] lv, input logic su, input logic sd,
                         input logic e, input logic [1:0] md,
                         input logic [2:0] ec, input logic [1:0] ed, input logic et);
        load = ld; load_val = 5'd0; load_val2 = lv;
        start_up = su; start_down = sd; en = e; mode = md;
        @(posedge Clk); #1;
        tag++;
        q2.push_back('{{2'b00, ec}, ed, et, tag});
        @(negedge Clk); #1;
    endtask

    initial begin
        ClearN = 1'b0; load = 1'b0; load_val = 5'd0; load_val2 = 3'd0;
        start_up = 1'b0; start_down = 1'b0; en = 1'b0; mode = MODE_WRAP;
        #2;
        chk("reset_initial", 0, count, dir, tc, 5'd0, DIR_IDLE, 1'b0);
        @(negedge Clk); #1;
        ClearN = 1'b1;

        // Asynchronous reset mid-count
        step(1'b1, 5'd13, 1'b1, 1'b0, 1'b0, MODE_WRAP, 5'd13, DIR_UP, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b0, MODE_WRAP, 5'd13, DIR_UP, 1'b0);
        ClearN = 1'b0;
        #1;
        chk("async_reset", tag, count, dir, tc, 5'd0, DIR_IDLE, 1'b0);
        @(posedge Clk); @(negedge Clk); #1;
        ClearN = 1'b1;

        // BOUNCE across the full range, 60 enabled steps
        step(1'b1, 5'd0, 1'b1, 1'b0, 1'b1, MODE_BOUNCE, 5'd0, DIR_UP, 1'b0);
        for (int i = 1; i <= 24; i++)
            step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MODE_BOUNCE, 5'(i),
                 (i == 24) ? DIR_DOWN : DIR_UP, (i == 24));
        for (int i = 23; i >= 0; i--)
            step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MODE_BOUNCE, 5'(i),
                 (i == 0) ? DIR_UP : DIR_DOWN, (i == 0));
        for (int i = 1; i <= 12; i++)
            step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MODE_BOUNCE, 5'(i), DIR_UP, 1'b0);

        // WRAP up through the rollover, then down through it
        step(1'b1, 5'd23, 1'b1, 1'b0, 1'b1, MODE_WRAP, 5'd23, DIR_UP, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd24, DIR_UP, 1'b1);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd0,  DIR_UP, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd1,  DIR_UP, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b1, 1'b1, MODE_WRAP, 5'd1,  DIR_DOWN, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd0,  DIR_DOWN, 1'b1);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd24, DIR_DOWN, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd23, DIR_DOWN, 1'b0);

        // SATURATE: single tc, then idle; restart at the endpoint holds with no tc
        step(1'b1, 5'd22, 1'b1, 1'b0, 1'b1, MODE_SAT, 5'd22, DIR_UP, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_SAT, 5'd23, DIR_UP, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_SAT, 5'd24, DIR_IDLE, 1'b1);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_SAT, 5'd24, DIR_IDLE, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_SAT, 5'd24, DIR_IDLE, 1'b0);
        step(1'b0, 5'd0,  1'b1, 1'b0, 1'b1, MODE_SAT, 5'd24, DIR_UP, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_SAT, 5'd24, DIR_IDLE, 1'b0);

        // Clamp and priority
        step(1'b1, 5'd31, 1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd24, DIR_IDLE, 1'b0);
        step(1'b1, 5'd5,  1'b0, 1'b1, 1'b1, MODE_WRAP, 5'd5,  DIR_DOWN, 1'b0);
        step(1'b0, 5'd0,  1'b1, 1'b1, 1'b1, MODE_WRAP, 5'd5,  DIR_DOWN, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd4,  DIR_DOWN, 1'b0);
        step(1'b0, 5'd0,  1'b0, 1'b0, 1'b1, MODE_HOLD, 5'd4,  DIR_DOWN, 1'b0);
        step(1'b1, 5'd24, 1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd24, DIR_DOWN, 1'b0);

        // en gating; en=0 right after a tc clears it
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd23, DIR_DOWN, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, MODE_WRAP, 5'd23, DIR_DOWN, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd22, DIR_DOWN, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, MODE_WRAP, 5'd22, DIR_DOWN, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd21, DIR_DOWN, 1'b0);
        step(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, MODE_WRAP, 5'd1,  DIR_DOWN, 1'b0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 5'd0,  DIR_DOWN, 1'b1);
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, MODE_WRAP, 5'd0,  DIR_DOWN, 1'b0);

        // WRAP on the WIDTH=3, MODULUS=8 instance: full-range 7 -> 0
        step2(1'b1, 3'd6, 1'b1, 1'b0, 1'b1, MODE_WRAP, 3'd6, DIR_UP, 1'b0);
        step2(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 3'd7, DIR_UP, 1'b1);
        step2(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 3'd0, DIR_UP, 1'b0);
        step2(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 3'd1, DIR_UP, 1'b0);
        step2(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, MODE_WRAP, 3'd1, DIR_DOWN, 1'b0);
        step2(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 3'd0, DIR_DOWN, 1'b1);
        step2(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 3'd7, DIR_DOWN, 1'b0);
        step2(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, MODE_WRAP, 3'd6, DIR_DOWN, 1'b0);

        for (int i = 0; i < 10 && (q1.size() + q2.size()) > 0; i++) begin
            @(negedge Clk); #1;
        end
        n_total++;
        if ((q1.size() + q2.size()) == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expectations, want 0", q1.size() + q2.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
